// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, early exit; CMP_SIGNED_EN adds signed_mode.
// Latency: k edges from accept to out_valid (k = first differing chunk index + 1, max WIDTH/CHUNK).
// Backpressure: result held until out_ready; in_ready only in IDLE or while a held result is being taken.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     A,
  input  logic [WIDTH-1:0]                     B,
`ifdef CMP_SIGNED_EN
  input  logic                                 signed_mode,
`endif
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 A_is_greater,
  output logic                                 B_is_greater,
  output logic                                 are_equal,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]     chunks_used
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] ALL_USED = CW'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [CW-1:0]     idx;
  logic [WIDTH-1:0]  a_load;
  logic [WIDTH-1:0]  b_load;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic              accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Operands shift left after each equal chunk, so the live chunk is always the top slice.
  assign a_chunk = a_q[WIDTH-1 -: CHUNK];
  assign b_chunk = b_q[WIDTH-1 -: CHUNK];

  // Flipping the sign bit of both operands maps two's complement order onto unsigned order.
  always_comb begin
    a_load = A;
    b_load = B;
`ifdef CMP_SIGNED_EN
    if (signed_mode) begin
      a_load[WIDTH-1] = ~A[WIDTH-1];
      b_load[WIDTH-1] = ~B[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      idx          <= '0;
      out_valid    <= 1'b0;
      A_is_greater <= 1'b0;
      B_is_greater <= 1'b0;
      are_equal    <= 1'b0;
      chunks_used  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= a_load;
            b_q   <= b_load;
            idx   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (a_chunk != b_chunk) begin
            A_is_greater <= (a_chunk > b_chunk);
            B_is_greater <= (a_chunk < b_chunk);
            chunks_used  <= idx + CW'(1);
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (idx == LAST_IDX) begin
            are_equal   <= 1'b1;
            chunks_used <= ALL_USED;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + CW'(1);
            a_q <= a_q << CHUNK;
            b_q <= b_q << CHUNK;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            A_is_greater <= 1'b0;
            B_is_greater <= 1'b0;
            are_equal    <= 1'b0;
            if (accept) begin
              a_q   <= a_load;
              b_q   <= b_load;
              idx   <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
